datapath_ctrl: RTL and testbench
================================

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 Parameters: none; all widths are fixed (16-bit data, 3-bit register index, 8-bit immediate).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 cmd_valid  input  1  command present on the cmd_* inputs.
REQ-005 cmd_ready  output  1  controller can accept a command.
REQ-006 cmd_op  input  3  opcode: 000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN; 110 and 111 are illegal.
REQ-007 cmd_rd, cmd_rn, cmd_rm  input  3 each  destination, operand-A and operand-B register indices.
REQ-008 cmd_shift  input  2  shift code applied to operand B.
REQ-009 cmd_imm8  input  8  immediate operand for MOVI.
REQ-010 done  output  1  one-cycle pulse when a legal command completes.
REQ-011 err  output  1  one-cycle pulse when an illegal opcode is accepted.
REQ-012 Datapath drive outputs: readnum 3, writenum 3, vsel 1, loada 1, loadb 1, asel 1, bsel 1, shift 2, ALUop 2, loadc 1, loads 1, write 1, datapath_in 16.

Function
REQ-013 All command fields are captured into internal registers on the accept cycle (cmd_valid & cmd_ready); the cmd_* inputs are don't-care at all other times.
REQ-014 cmd_ready = 1 only in state IDLE, and is forced to 0 while reset_n = 0.
REQ-015 The block is a Moore machine: every output is a function of the state and the captured fields only.
REQ-016 States: IDLE, WIMM, GETA, GETB, EXEC, WB, DONE, ERR.
REQ-017 Transitions from IDLE on accept: MOVI -> WIMM; MOV and MVN -> GETB; ADD, AND and CMP -> GETA; illegal -> ERR.
REQ-018 Subsequent transitions: GETA -> GETB -> EXEC; EXEC -> DONE for CMP, otherwise EXEC -> WB; WIMM -> DONE; WB -> DONE; DONE -> IDLE; ERR -> IDLE.
REQ-019 WIMM: write=1, vsel=1, writenum=rd.
REQ-020 GETA: readnum=rn, loada=1.
REQ-021 GETB: readnum=rm, loadb=1.
REQ-022 EXEC: bsel=0, shift=captured shift, asel=1 for MOV and MVN (A forced to 0) and 0 otherwise.
REQ-023 EXEC ALUop per opcode: MOV 00, ADD 00, CMP 01, AND 10, MVN 11.
REQ-024 EXEC load enables: loadc=1 and loads=0 for every opcode except CMP; CMP uses loadc=0, loads=1.
REQ-025 WB: write=1, vsel=0, writenum=rd.
REQ-026 DONE asserts done=1; ERR asserts err=1; neither state drives any datapath strobe.
REQ-027 Any strobe, readnum, writenum, shift or ALUop not listed for the current state is 0.
REQ-028 datapath_in = {8{imm8[7]}, imm8}, sign-extended from the captured immediate, and is driven in all states.
REQ-029 Accept-to-done latency in cycles (accept = cycle 0, done cycle given): MOVI 2, MOV 4, MVN 4, CMP 4, ADD 5, AND 5; illegal opcode gives err in cycle 1.
REQ-030 cmd_valid while cmd_ready=0 is ignored; the requester holds the command until it is accepted.
REQ-031 Back-to-back operation: a new command can be accepted in the IDLE cycle immediately after DONE or ERR.

Reset
REQ-032 When reset_n=0 at a clock edge, state becomes IDLE and all captured fields become 0.
REQ-033 All strobes, done and err are 0 from the next cycle; datapath_in is 0 from the next cycle.
REQ-034 Reset mid-command aborts it: no write, loadc or loads is asserted after the reset edge, and no done is produced for that command.

Structure
REQ-035 Opcode, ALUop and state encodings live as constants in shared package datapath_pkg.
REQ-036 One combinational sub-module, dp_ctrl_decode, maps (state, captured op, rd, rn, rm, shift) to the datapath drive outputs.
REQ-037 The state register and the captured-field registers live in datapath_ctrl.

Verification
REQ-038 Bench connects to the existing datapath; after reset, MOVI rd=0 imm8=0x07, then MOVI rd=1 imm8=0xFE -> R0=0x0007, R1=0xFFFE, done 2 cycles after each accept.
REQ-039 Then ADD rd=2 rn=0 rm=1 shift=00 -> datapath_out=0x0005, R2=0x0005, done 5 cycles after accept.
REQ-040 Then CMP rn=0 rm=0 -> Z_out=1, no register write, done 4 cycles after accept; then MVN rd=3 rm=0 -> R3=0xFFF8.
REQ-041 Accept cmd_op=111 -> err pulse in cycle 1, no strobe asserted, cmd_ready=1 in cycle 2.
REQ-042 Assert reset_n=0 during EXEC of an ADD -> IDLE next cycle, destination register unchanged, no done pulse.
REQ-043 Hold cmd_valid=1 continuously with changing cmd_* values while busy -> only values present on accept cycles are executed.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared encodings for the datapath controller: opcodes, ALU operations and FSM states.
// Also holds small decode helpers used by the controller and its decoder.
package datapath_pkg;

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_CMP  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVN  = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WIMM,
    S_GETA,
    S_GETB,
    S_EXEC,
    S_WB,
    S_DONE,
    S_ERR
  } state_e;

  function automatic logic [1:0] alu_op_for(input logic [2:0] op);
    logic [1:0] res;
    res = ALU_ADD;
    case (op)
      OP_MOV:  res = ALU_ADD;
      OP_ADD:  res = ALU_ADD;
      OP_CMP:  res = ALU_SUB;
      OP_AND:  res = ALU_AND;
      OP_MVN:  res = ALU_NOT;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

  // MOV and MVN only use operand B, so operand A is forced to zero.
  function automatic logic b_only_op(input logic [2:0] op);
    return (op == OP_MOV) || (op == OP_MVN);
  endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// Command handshake between a requester and the datapath controller,
// including the done/err completion pulses.
interface datapath_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_rd;
  logic [2:0] cmd_rn;
  logic [2:0] cmd_rm;
  logic [1:0] cmd_shift;
  logic [7:0] cmd_imm8;
  logic       done;
  logic       err;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm8,
    input  cmd_ready, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm8,
    output cmd_ready, done, err
  );
endinterface

// File: rtl/dp_ctrl_decode.sv
// Combinational decode of controller state plus captured command fields into
// the datapath strobes; anything not driven by the current state stays 0.
module dp_ctrl_decode
  import datapath_pkg::*;
(
  input  state_e     state_i,
  input  logic [2:0] op_i,
  input  logic [2:0] rd_i,
  input  logic [2:0] rn_i,
  input  logic [2:0] rm_i,
  input  logic [1:0] shift_i,
  output logic [2:0] readnum_o,
  output logic [2:0] writenum_o,
  output logic       vsel_o,
  output logic       loada_o,
  output logic       loadb_o,
  output logic       asel_o,
  output logic       bsel_o,
  output logic [1:0] shift_o,
  output logic [1:0] aluop_o,
  output logic       loadc_o,
  output logic       loads_o,
  output logic       write_o
);

  always_comb begin
    readnum_o  = 3'd0;
    writenum_o = 3'd0;
    vsel_o     = 1'b0;
    loada_o    = 1'b0;
    loadb_o    = 1'b0;
    asel_o     = 1'b0;
    bsel_o     = 1'b0;
    shift_o    = 2'd0;
    aluop_o    = 2'd0;
    loadc_o    = 1'b0;
    loads_o    = 1'b0;
    write_o    = 1'b0;
    case (state_i)
      S_WIMM: begin
        write_o    = 1'b1;
        vsel_o     = 1'b1;
        writenum_o = rd_i;
      end
      S_GETA: begin
        readnum_o = rn_i;
        loada_o   = 1'b1;
      end
      S_GETB: begin
        readnum_o = rm_i;
        loadb_o   = 1'b1;
      end
      S_EXEC: begin
        bsel_o  = 1'b0;
        shift_o = shift_i;
        asel_o  = b_only_op(op_i);
        aluop_o = alu_op_for(op_i);
        // CMP only updates status; every other op latches the result in C.
        if (op_i == OP_CMP) loads_o = 1'b1;
        else                loadc_o = 1'b1;
      end
      S_WB: begin
        write_o    = 1'b1;
        vsel_o     = 1'b0;
        writenum_o = rd_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Moore controller sequencing register reads, ALU execution and write-back
// on an external 16-bit datapath, one command at a time.
module datapath_ctrl
  import datapath_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  datapath_ctrl_if.slave   cmd,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             vsel,
  output logic             loada,
  output logic             loadb,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic             loadc,
  output logic             loads,
  output logic             write,
  output logic [15:0]      datapath_in
);

  state_e     state_q, state_d;
  logic [2:0] op_q, rd_q, rn_q, rm_q;
  logic [1:0] shift_q;
  logic [7:0] imm_q;
  logic       accept;

  assign cmd.cmd_ready = (state_q == S_IDLE) && reset_n;
  assign cmd.done      = (state_q == S_DONE);
  assign cmd.err       = (state_q == S_ERR);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      rd_q    <= 3'd0;
      rn_q    <= 3'd0;
      rm_q    <= 3'd0;
      shift_q <= 2'd0;
      imm_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= cmd.cmd_op;
        rd_q    <= cmd.cmd_rd;
        rn_q    <= cmd.cmd_rn;
        rm_q    <= cmd.cmd_rm;
        shift_q <= cmd.cmd_shift;
        imm_q   <= cmd.cmd_imm8;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_MOVI:                state_d = S_WIMM;
            OP_MOV, OP_MVN:         state_d = S_GETB;
            OP_ADD, OP_AND, OP_CMP: state_d = S_GETA;
            default:                state_d = S_ERR;
          endcase
        end
      end
      S_WIMM:  state_d = S_DONE;
      S_GETA:  state_d = S_GETB;
      S_GETB:  state_d = S_EXEC;
      S_EXEC:  state_d = (op_q == OP_CMP) ? S_DONE : S_WB;
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Immediate is sign-extended from the captured byte and driven in every state.
  assign datapath_in[7:0] = imm_q;
  for (genvar gi = 8; gi < 16; gi++) begin : g_sext
    assign datapath_in[gi] = imm_q[7];
  end

  dp_ctrl_decode u_decode (
    .state_i    (state_q),
    .op_i       (op_q),
    .rd_i       (rd_q),
    .rn_i       (rn_q),
    .rm_i       (rm_q),
    .shift_i    (shift_q),
    .readnum_o  (readnum),
    .writenum_o (writenum),
    .vsel_o     (vsel),
    .loada_o    (loada),
    .loadb_o    (loadb),
    .asel_o     (asel),
    .bsel_o     (bsel),
    .shift_o    (shift),
    .aluop_o    (ALUop),
    .loadc_o    (loadc),
    .loads_o    (loads),
    .write_o    (write)
  );

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: drives commands into a behavioural datapath and
// compares register file, C and Z against an instruction-level model.
module tb_datapath_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [2:0]  readnum, writenum;
  logic        vsel, loada, loadb, asel, bsel, loadc, loads, write;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;

  datapath_ctrl_if cmd_if ();

  datapath_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd         (cmd_if),
    .readnum     (readnum),
    .writenum    (writenum),
    .vsel        (vsel),
    .loada       (loada),
    .loadb       (loadb),
    .asel        (asel),
    .bsel        (bsel),
    .shift       (shift),
    .ALUop       (ALUop),
    .loadc       (loadc),
    .loads       (loads),
    .write       (write),
    .datapath_in (datapath_in)
  );

  // Behavioural stand-in for the datapath the controller drives.
  logic [15:0] rf [8];
  logic [15:0] a_reg, b_reg, c_reg, b_sh, ain, bin, alu_out;
  logic        z_reg;

  always_comb begin
    case (shift)
      2'b00:   b_sh = b_reg;
      2'b01:   b_sh = {b_reg[14:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_reg[15:1]};
      default: b_sh = {b_reg[15], b_reg[15:1]};
    endcase
    ain = asel ? 16'h0000 : a_reg;
    bin = bsel ? {{11{datapath_in[4]}}, datapath_in[4:0]} : b_sh;
    case (ALUop)
      2'b00:   alu_out = ain + bin;
      2'b01:   alu_out = ain - bin;
      2'b10:   alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (write) rf[writenum] <= vsel ? datapath_in : c_reg;
    if (loada) a_reg <= rf[readnum];
    if (loadb) b_reg <= rf[readnum];
    if (loadc) c_reg <= alu_out;
    if (loads) z_reg <= (alu_out == 16'h0000);
  end

  // Instruction-level reference model.
  logic [15:0] m_rf [8];
  logic [15:0] m_c;
  logic        m_z;
  bit          m_c_ok = 0;
  bit          m_z_ok = 0;

  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] shv(input logic [15:0] v, input logic [1:0] s);
    case (s)
      2'd0:    return v;
      2'd1:    return v * 16'd2;
      2'd2:    return v / 16'd2;
      default: return 16'($signed(v) >>> 1);
    endcase
  endfunction

  function automatic logic [15:0] sext(input logic [7:0] b);
    return 16'($signed(b));
  endfunction

  function automatic logic [17:0] strobes();
    return {readnum, writenum, vsel, loada, loadb, asel, bsel, shift, ALUop, loadc, loads, write};
  endfunction

  task automatic model_apply(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                             input logic [2:0] rm, input logic [1:0] sh, input logic [7:0] imm);
    logic [15:0] bv, r;
    bv = shv(m_rf[rm], sh);
    r  = 16'h0;
    case (op)
      3'd0: m_rf[rd] = sext(imm);
      3'd1: begin r = bv;            m_c = r; m_c_ok = 1; m_rf[rd] = r; end
      3'd2: begin r = m_rf[rn] + bv; m_c = r; m_c_ok = 1; m_rf[rd] = r; end
      3'd3: begin m_z = ((m_rf[rn] - bv) == 16'h0); m_z_ok = 1; end
      3'd4: begin r = m_rf[rn] & bv; m_c = r; m_c_ok = 1; m_rf[rd] = r; end
      3'd5: begin r = ~bv;           m_c = r; m_c_ok = 1; m_rf[rd] = r; end
      default: ;
    endcase
  endtask

  // Issue one command from an IDLE-cycle negedge; returns at the negedge of
  // the IDLE cycle that follows done/err. junk keeps cmd_valid high with
  // random fields while the controller is busy.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic [1:0] sh, input logic [7:0] imm,
                         input bit junk);
    int lat, exp_lat, n_a, n_b, n_c, n_s, n_w;
    int e_a, e_b, e_c, e_s, e_w;
    bit got_done, got_err, exp_err, bad;
    lat = 0; n_a = 0; n_b = 0; n_c = 0; n_s = 0; n_w = 0;
    got_done = 0; got_err = 0;

    checks++;
    if ({cmd_if.cmd_ready, cmd_if.done, cmd_if.err} !== 3'b100) begin
      errors++;
      $display("FAIL idle_before_cmd ready/done/err got=%b exp=100", {cmd_if.cmd_ready, cmd_if.done, cmd_if.err});
    end

    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op = op; cmd_if.cmd_rd = rd; cmd_if.cmd_rn = rn;
    cmd_if.cmd_rm = rm; cmd_if.cmd_shift = sh; cmd_if.cmd_imm8 = imm;
    @(posedge clk);

    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_a += int'(loada); n_b += int'(loadb); n_c += int'(loadc);
      n_s += int'(loads); n_w += int'(write);
      if (cmd_if.done === 1'b1 || cmd_if.err === 1'b1) begin
        got_done = cmd_if.done; got_err = cmd_if.err; lat = k;
        checks++;
        if (strobes() !== 18'd0) begin
          errors++;
          $display("FAIL end_strobes op=%0d got=%h exp=0", op, strobes());
        end
        checks++;
        if (datapath_in !== sext(imm)) begin
          errors++;
          $display("FAIL datapath_in op=%0d got=%h exp=%h", op, datapath_in, sext(imm));
        end
        break;
      end
      if (junk) begin
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op = 3'($urandom_range(0, 7)); cmd_if.cmd_rd = 3'($urandom_range(0, 7));
        cmd_if.cmd_rn = 3'($urandom_range(0, 7)); cmd_if.cmd_rm = 3'($urandom_range(0, 7));
        cmd_if.cmd_shift = 2'($urandom_range(0, 3)); cmd_if.cmd_imm8 = 8'($urandom_range(0, 255));
      end else begin
        cmd_if.cmd_valid = 1'b0;
      end
    end
    cmd_if.cmd_valid = 1'b0;

    exp_err = (op > 3'd5);
    case (op)
      3'd0:       begin exp_lat = 2; e_a = 0; e_b = 0; e_c = 0; e_s = 0; e_w = 1; end
      3'd1, 3'd5: begin exp_lat = 4; e_a = 0; e_b = 1; e_c = 1; e_s = 0; e_w = 1; end
      3'd2, 3'd4: begin exp_lat = 5; e_a = 1; e_b = 1; e_c = 1; e_s = 0; e_w = 1; end
      3'd3:       begin exp_lat = 4; e_a = 1; e_b = 1; e_c = 0; e_s = 1; e_w = 0; end
      default:    begin exp_lat = 1; e_a = 0; e_b = 0; e_c = 0; e_s = 0; e_w = 0; end
    endcase

    checks++;
    if (lat != exp_lat || got_err != exp_err || got_done != !exp_err) begin
      errors++;
      $display("FAIL completion op=%0d got lat=%0d done=%0b err=%0b exp lat=%0d done=%0b err=%0b",
               op, lat, got_done, got_err, exp_lat, !exp_err, exp_err);
    end
    checks++;
    if (n_a != e_a || n_b != e_b || n_c != e_c || n_s != e_s || n_w != e_w) begin
      errors++;
      $display("FAIL strobe_counts op=%0d got a/b/c/s/w=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d/%0d",
               op, n_a, n_b, n_c, n_s, n_w, e_a, e_b, e_c, e_s, e_w);
    end

    model_apply(op, rd, rn, rm, sh, imm);
    bad = 0;
    for (int i = 0; i < 8; i++) if (rf[i] !== m_rf[i]) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL regfile op=%0d rd=%0d got R[rd]=%h exp=%h", op, rd, rf[rd], m_rf[rd]);
    end
    if (m_c_ok) begin
      checks++;
      if (c_reg !== m_c) begin
        errors++;
        $display("FAIL datapath_out op=%0d got=%h exp=%h", op, c_reg, m_c);
      end
    end
    if (m_z_ok) begin
      checks++;
      if (z_reg !== m_z) begin
        errors++;
        $display("FAIL z_out op=%0d got=%b exp=%b", op, z_reg, m_z);
      end
    end
    $display("cmd op=%0d rd=%0d rn=%0d rm=%0d sh=%0d imm=%h lat=%0d err=%0b R[rd]=%h",
             op, rd, rn, rm, sh, imm, lat, got_err, rf[rd]);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op = 3'd2; cmd_if.cmd_rd = 3'd5; cmd_if.cmd_rn = 3'd6;
    cmd_if.cmd_rm = 3'd7; cmd_if.cmd_shift = 2'd3; cmd_if.cmd_imm8 = 8'hA5;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_if.cmd_ready, cmd_if.done, cmd_if.err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_handshake got=%b exp=000", {cmd_if.cmd_ready, cmd_if.done, cmd_if.err});
    end
    checks++;
    if (strobes() !== 18'd0 || datapath_in !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs got strobes=%h din=%h exp=0/0", strobes(), datapath_in);
    end
    cmd_if.cmd_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b exp=1", cmd_if.cmd_ready);
    end
    $display("reset ready=%b din=%h", cmd_if.cmd_ready, datapath_in);
  endtask

  task automatic test_directed();
    run_cmd(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'h07, 0);
    run_cmd(3'd0, 3'd1, 3'd0, 3'd0, 2'd0, 8'hFE, 0);
    checks++;
    if (rf[0] !== 16'h0007 || rf[1] !== 16'hFFFE) begin
      errors++;
      $display("FAIL movi_values got R0=%h R1=%h exp 0007/fffe", rf[0], rf[1]);
    end
    run_cmd(3'd2, 3'd2, 3'd0, 3'd1, 2'd0, 8'h00, 0);
    checks++;
    if (c_reg !== 16'h0005 || rf[2] !== 16'h0005) begin
      errors++;
      $display("FAIL add_value got C=%h R2=%h exp 0005/0005", c_reg, rf[2]);
    end
    run_cmd(3'd3, 3'd0, 3'd0, 3'd0, 2'd0, 8'h00, 0);
    checks++;
    if (z_reg !== 1'b1) begin
      errors++;
      $display("FAIL cmp_z got=%b exp=1", z_reg);
    end
    run_cmd(3'd5, 3'd3, 3'd0, 3'd0, 2'd0, 8'h00, 0);
    checks++;
    if (rf[3] !== 16'hFFF8) begin
      errors++;
      $display("FAIL mvn_value got=%h exp=fff8", rf[3]);
    end
  endtask

  task automatic test_illegal();
    run_cmd(3'd7, 3'd4, 3'd1, 3'd2, 2'd1, 8'h81, 0);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_err got=%b exp=1", cmd_if.cmd_ready);
    end
    run_cmd(3'd6, 3'd2, 3'd3, 3'd0, 2'd2, 8'h3C, 1);
  endtask

  task automatic test_reset_abort();
    bit seen_done, seen_wr;
    run_cmd(3'd0, 3'd5, 3'd0, 3'd0, 2'd0, 8'h42, 0);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op = 3'd2; cmd_if.cmd_rd = 3'd5; cmd_if.cmd_rn = 3'd0;
    cmd_if.cmd_rm = 3'd1; cmd_if.cmd_shift = 2'd0; cmd_if.cmd_imm8 = 8'h5A;
    @(posedge clk);
    @(negedge clk); cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (loadc !== 1'b1) begin
      errors++;
      $display("FAIL abort_exec_reached loadc got=%b exp=1", loadc);
    end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (strobes() !== 18'd0 || datapath_in !== 16'h0000 ||
        {cmd_if.cmd_ready, cmd_if.done, cmd_if.err} !== 3'b000) begin
      errors++;
      $display("FAIL abort_outputs got strobes=%h din=%h rde=%b exp 0/0/000", strobes(), datapath_in,
               {cmd_if.cmd_ready, cmd_if.done, cmd_if.err});
    end
    reset_n = 1'b1;
    // C was loaded by the EXEC cycle before the reset edge took effect.
    m_c = m_rf[0] + m_rf[1];
    m_c_ok = 1;
    seen_done = 0; seen_wr = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen_done |= cmd_if.done;
      seen_wr |= (write | loadc | loads);
    end
    checks++;
    if (seen_done || seen_wr) begin
      errors++;
      $display("FAIL abort_quiet got done=%b wr=%b exp 0/0", seen_done, seen_wr);
    end
    checks++;
    if (rf[5] !== m_rf[5] || c_reg !== m_c) begin
      errors++;
      $display("FAIL abort_regs got R5=%h C=%h exp %h/%h", rf[5], c_reg, m_rf[5], m_c);
    end
    $display("abort R5=%h C=%h ready=%b", rf[5], c_reg, cmd_if.cmd_ready);
  endtask

  task automatic test_hold_random();
    for (int i = 0; i < 8; i++)
      run_cmd(3'd0, 3'(i), 3'd0, 3'd0, 2'd0, 8'($urandom_range(0, 255)), 0);
    for (int n = 0; n < 40; n++)
      run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
              bit'($urandom_range(0, 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_reset_abort();
    test_hold_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
